// File: rtl/rah_mc_pkg.sv
// Shared header layout and parser state encoding for the RAH multi-channel decoder.
package rah_mc_pkg;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;

  localparam int MAGIC_LSB = 24;
  localparam int MAGIC_W   = 8;
  localparam int LEN_LSB   = 8;
  localparam int LEN_W     = 16;
  localparam int ID_LSB    = 0;
  localparam int ID_W      = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    DROP    = 2'd2
  } rah_state_e;

endpackage

// File: rtl/rah_sync_fifo.sv
// Single-clock FIFO with inferred RAM, registered read port and registered status flags.
module rah_sync_fifo #(
  parameter int DATA_WIDTH          = 32,
  parameter int FIFO_DEPTH          = 512,
  parameter int ALMOST_EMPTY_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_empty,
  output logic                  o_almost_empty,
  output logic                  o_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [31:0]   AE_THRESH = 32'(ALMOST_EMPTY_THRESH);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         w_count_next;
  logic                  r_empty;
  logic                  r_almost_empty;
  logic                  r_full;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;
  logic                  w_push;
  logic                  w_pop;

  assign w_pop      = i_pop && !r_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted
  assign w_push     = i_push && (!r_full || w_pop);
  assign o_overflow = i_push && r_full && !w_pop;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_pop;
      if (w_pop) begin
        r_rd_data <= r_mem[r_rd_ptr];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_full         <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count        <= w_count_next;
      r_empty        <= (w_count_next == '0);
      r_almost_empty <= (32'(w_count_next) <= AE_THRESH);
      r_full         <= (w_count_next == DEPTH_C);
    end
  end

  assign o_rd_data      = r_rd_data;
  assign o_rd_valid     = r_rd_valid;
  assign o_empty        = r_empty;
  assign o_almost_empty = r_almost_empty;

endmodule

// File: rtl/rah_mc_decoder.sv
// Header parser that steers MIPI payload words into per-application FIFOs,
// with per-app sticky overflow flags and a selectable overflow policy.
module rah_mc_decoder
  import rah_mc_pkg::*;
#(
  parameter int DATA_WIDTH          = 32,
  parameter int TOTAL_APPS          = 4,
  parameter int FIFO_DEPTH          = 512,
  parameter int ALMOST_EMPTY_THRESH = 4,
  parameter int DROP_PACKET_ON_FULL = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DATA_WIDTH-1:0]            mipi_data,
  input  logic                             mipi_rx_valid,
  input  logic [TOTAL_APPS-1:0]            request_data,
  input  logic [TOTAL_APPS-1:0]            err_clear,
  output logic [TOTAL_APPS*DATA_WIDTH-1:0] rd_data,
  output logic [TOTAL_APPS-1:0]            rd_valid,
  output logic [TOTAL_APPS-1:0]            data_queue_empty,
  output logic [TOTAL_APPS-1:0]            data_queue_almost_empty,
  output logic                             end_of_packet,
  output logic                             hdr_error,
  output logic [TOTAL_APPS-1:0]            error
);

  localparam bit DROP_PKT = (DROP_PACKET_ON_FULL != 0);

  rah_state_e        r_state;
  rah_state_e        w_state_next;
  logic [LEN_W-1:0]  r_rem;
  logic [LEN_W-1:0]  w_rem_next;
  logic [ID_W-1:0]   r_id;
  logic [ID_W-1:0]   w_id_next;

  logic [MAGIC_W-1:0] w_magic;
  logic [LEN_W-1:0]   w_len;
  logic [ID_W-1:0]    w_hdr_id;
  logic               w_magic_ok;
  logic               w_id_ok;

  logic                  w_push;
  logic [TOTAL_APPS-1:0] w_ovf_vec;
  logic                  w_ovf;
  logic                  w_eop_next;
  logic                  w_hdr_err_next;
  logic                  r_eop;
  logic                  r_hdr_err;
  logic [TOTAL_APPS-1:0] r_error;

  assign w_magic    = mipi_data[MAGIC_LSB +: MAGIC_W];
  assign w_len      = mipi_data[LEN_LSB +: LEN_W];
  assign w_hdr_id   = mipi_data[ID_LSB +: ID_W];
  assign w_magic_ok = (w_magic == HDR_MAGIC);
  assign w_id_ok    = ({{(32-ID_W){1'b0}}, w_hdr_id} < 32'(TOTAL_APPS));

  assign w_push = mipi_rx_valid && (r_state == PAYLOAD);
  assign w_ovf  = |w_ovf_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_id    <= '0;
    end else begin
      r_state <= w_state_next;
      r_rem   <= w_rem_next;
      r_id    <= w_id_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_rem_next   = r_rem;
    w_id_next    = r_id;
    if (mipi_rx_valid) begin
      case (r_state)
        IDLE: begin
          if (w_magic_ok && !w_id_ok) begin
            // An unroutable header with no payload has nothing left to skip
            if (w_len != '0) begin
              w_state_next = DROP;
              w_rem_next   = w_len;
            end
          end else if (w_magic_ok && (w_len != '0)) begin
            w_state_next = PAYLOAD;
            w_rem_next   = w_len;
            w_id_next    = w_hdr_id;
          end
        end
        PAYLOAD: begin
          w_rem_next = r_rem - 1'b1;
          if (r_rem == 16'd1) begin
            w_state_next = IDLE;
          end else if (w_ovf && DROP_PKT) begin
            w_state_next = DROP;
          end
        end
        DROP: begin
          w_rem_next = r_rem - 1'b1;
          if (r_rem == 16'd1) begin
            w_state_next = IDLE;
          end
        end
        default: begin
          w_state_next = IDLE;
          w_rem_next   = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_eop_next     = 1'b0;
    w_hdr_err_next = 1'b0;
    if (mipi_rx_valid) begin
      case (r_state)
        IDLE: begin
          w_hdr_err_next = !w_magic_ok || !w_id_ok;
          w_eop_next     = w_magic_ok && w_id_ok && (w_len == '0);
        end
        PAYLOAD: begin
          w_eop_next = (r_rem == 16'd1) && !(w_ovf && DROP_PKT);
        end
        default: begin
          w_eop_next     = 1'b0;
          w_hdr_err_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_eop     <= 1'b0;
      r_hdr_err <= 1'b0;
      r_error   <= '0;
    end else begin
      r_eop     <= w_eop_next;
      r_hdr_err <= w_hdr_err_next;
      // a new overflow outranks a clear arriving in the same cycle
      r_error   <= (r_error & ~err_clear) | w_ovf_vec;
    end
  end

  for (genvar gi = 0; gi < TOTAL_APPS; gi++) begin : g_app
    logic w_push_app;

    assign w_push_app = w_push && (r_id == ID_W'(gi));

    rah_sync_fifo #(
      .DATA_WIDTH          (DATA_WIDTH),
      .FIFO_DEPTH          (FIFO_DEPTH),
      .ALMOST_EMPTY_THRESH (ALMOST_EMPTY_THRESH)
    ) u_fifo (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_push         (w_push_app),
      .i_data         (mipi_data),
      .i_pop          (request_data[gi]),
      .o_rd_data      (rd_data[gi*DATA_WIDTH +: DATA_WIDTH]),
      .o_rd_valid     (rd_valid[gi]),
      .o_empty        (data_queue_empty[gi]),
      .o_almost_empty (data_queue_almost_empty[gi]),
      .o_overflow     (w_ovf_vec[gi])
    );
  end

  assign end_of_packet = r_eop;
  assign hdr_error     = r_hdr_err;
  assign error         = r_error;

endmodule

// File: tb/tb_rah_mc_decoder.sv
// Drives two decoders (word-drop and packet-drop overflow policies) with the same
// directed and random word stream and compares every output against a queue model.
module tb_rah_mc_decoder;

  localparam int DW     = 36;
  localparam int APPS   = 4;
  localparam int DEPTH  = 4;
  localparam int THRESH = 1;
  localparam int CHKW   = APPS * DW;

  localparam int ST_IDLE = 0;
  localparam int ST_PAY  = 1;
  localparam int ST_DROP = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [DW-1:0]   mipi_data = '0;
  logic            mipi_rx_valid = 1'b0;
  logic [APPS-1:0] request_data = '0;
  logic [APPS-1:0] err_clear = '0;

  logic [APPS*DW-1:0] o_rd_data [2];
  logic [APPS-1:0]    o_rd_valid [2];
  logic [APPS-1:0]    o_empty [2];
  logic [APPS-1:0]    o_aempty [2];
  logic               o_eop [2];
  logic               o_hdr [2];
  logic [APPS-1:0]    o_err [2];

  // reference model state, index d selects the decoder (d=1 is packet-drop)
  int              m_st [2];
  int              m_rem [2];
  int              m_id [2];
  logic [DW-1:0]   m_q [2*APPS][$];
  logic [DW-1:0]   m_rd [2*APPS];
  logic [APPS-1:0] m_rv [2];
  logic            m_eop [2];
  logic            m_hdr [2];
  logic [APPS-1:0] m_err [2];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  rah_mc_decoder #(
    .DATA_WIDTH(DW), .TOTAL_APPS(APPS), .FIFO_DEPTH(DEPTH),
    .ALMOST_EMPTY_THRESH(THRESH), .DROP_PACKET_ON_FULL(0)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .mipi_data(mipi_data), .mipi_rx_valid(mipi_rx_valid),
    .request_data(request_data), .err_clear(err_clear),
    .rd_data(o_rd_data[0]), .rd_valid(o_rd_valid[0]), .data_queue_empty(o_empty[0]),
    .data_queue_almost_empty(o_aempty[0]), .end_of_packet(o_eop[0]),
    .hdr_error(o_hdr[0]), .error(o_err[0])
  );

  rah_mc_decoder #(
    .DATA_WIDTH(DW), .TOTAL_APPS(APPS), .FIFO_DEPTH(DEPTH),
    .ALMOST_EMPTY_THRESH(THRESH), .DROP_PACKET_ON_FULL(1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .mipi_data(mipi_data), .mipi_rx_valid(mipi_rx_valid),
    .request_data(request_data), .err_clear(err_clear),
    .rd_data(o_rd_data[1]), .rd_valid(o_rd_valid[1]), .data_queue_empty(o_empty[1]),
    .data_queue_almost_empty(o_aempty[1]), .end_of_packet(o_eop[1]),
    .hdr_error(o_hdr[1]), .error(o_err[1])
  );

  function automatic logic [DW-1:0] hdr(input int len, input int id);
    hdr = {4'h0, 8'hA5, 16'(len), 8'(id)};
  endfunction

  task automatic chk(input string tag, input logic [CHKW-1:0] obs, input logic [CHKW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_st[d] = ST_IDLE; m_rem[d] = 0; m_id[d] = 0;
      m_rv[d] = '0; m_eop[d] = 1'b0; m_hdr[d] = 1'b0; m_err[d] = '0;
    end
    for (int i = 0; i < 2*APPS; i++) begin
      m_q[i].delete();
      m_rd[i] = '0;
    end
  endtask

  // One clock edge of the packet rules for decoder d.
  task automatic model_step(input int d, input logic v, input logic [DW-1:0] w,
                            input logic [APPS-1:0] req, input logic [APPS-1:0] clr);
    logic [APPS-1:0] popok;
    logic [APPS-1:0] set;
    bit push, full, last, pol;
    int tgt, magic, len, id;
    pol = (d == 1);
    popok = '0; set = '0; push = 0; tgt = 0;
    m_rv[d] = '0; m_eop[d] = 1'b0; m_hdr[d] = 1'b0;
    for (int a = 0; a < APPS; a++) popok[a] = req[a] && (m_q[d*APPS+a].size() != 0);
    if (v) begin
      magic = int'(w[31:24]); len = int'(w[23:8]); id = int'(w[7:0]);
      if (m_st[d] == ST_IDLE) begin
        if (magic != 8'hA5) m_hdr[d] = 1'b1;
        else if (id >= APPS) begin
          m_hdr[d] = 1'b1;
          if (len != 0) begin m_st[d] = ST_DROP; m_rem[d] = len; end
        end else if (len == 0) m_eop[d] = 1'b1;
        else begin m_st[d] = ST_PAY; m_rem[d] = len; m_id[d] = id; end
      end else if (m_st[d] == ST_PAY) begin
        tgt  = m_id[d];
        full = (m_q[d*APPS+tgt].size() == DEPTH) && !popok[tgt];
        last = (m_rem[d] == 1);
        m_rem[d]--;
        if (full) set[tgt] = 1'b1;
        else push = 1;
        if (last) begin
          m_st[d] = ST_IDLE;
          if (!(full && pol)) m_eop[d] = 1'b1;
        end else if (full && pol) m_st[d] = ST_DROP;
      end else begin
        m_rem[d]--;
        if (m_rem[d] == 0) m_st[d] = ST_IDLE;
      end
    end
    for (int a = 0; a < APPS; a++) begin
      if (popok[a]) begin
        m_rd[d*APPS+a] = m_q[d*APPS+a].pop_front();
        m_rv[d][a] = 1'b1;
      end
    end
    if (push) m_q[d*APPS+tgt].push_back(w);
    m_err[d] = (m_err[d] & ~clr) | set;
  endtask

  task automatic check_all(input int d);
    logic [APPS*DW-1:0] erd;
    logic [APPS-1:0] ee, eae;
    for (int a = 0; a < APPS; a++) begin
      erd[a*DW +: DW] = m_rd[d*APPS+a];
      ee[a]  = (m_q[d*APPS+a].size() == 0);
      eae[a] = (m_q[d*APPS+a].size() <= THRESH);
    end
    chk($sformatf("dut%0d rd_data", d), o_rd_data[d], erd);
    chk($sformatf("dut%0d rd_valid", d), CHKW'(o_rd_valid[d]), CHKW'(m_rv[d]));
    chk($sformatf("dut%0d empty", d), CHKW'(o_empty[d]), CHKW'(ee));
    chk($sformatf("dut%0d almost_empty", d), CHKW'(o_aempty[d]), CHKW'(eae));
    chk($sformatf("dut%0d end_of_packet", d), CHKW'(o_eop[d]), CHKW'(m_eop[d]));
    chk($sformatf("dut%0d hdr_error", d), CHKW'(o_hdr[d]), CHKW'(m_hdr[d]));
    chk($sformatf("dut%0d error", d), CHKW'(o_err[d]), CHKW'(m_err[d]));
  endtask

  task automatic cyc(input logic v, input logic [DW-1:0] w,
                     input logic [APPS-1:0] req, input logic [APPS-1:0] clr);
    mipi_rx_valid = v; mipi_data = w; request_data = req; err_clear = clr;
    @(posedge clk);
    model_step(0, v, w, req, clr);
    model_step(1, v, w, req, clr);
    @(negedge clk);
    check_all(0);
    check_all(1);
  endtask

  // Reset is asserted between clock edges and released on a falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    mipi_rx_valid = 1'b0; mipi_data = '0; request_data = '0; err_clear = '0;
    #3;
    model_reset();
    check_all(0);
    check_all(1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic word(input logic [DW-1:0] w);
    cyc(1'b1, w, '0, '0);
  endtask

  task automatic idle(input int n, input logic [APPS-1:0] req, input logic [APPS-1:0] clr);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, req, clr);
  endtask

  initial begin
    logic [DW-1:0] w;
    logic v;
    int r;

    do_reset();

    // three-word packet to app 1, then drain it (last request hits an empty queue)
    word(hdr(3, 1)); word(36'h11); word(36'h22); word(36'h33);
    idle(1, '0, '0);
    idle(4, 4'b0010, '0);

    // bad magic, then the next two words are themselves headers
    word({4'h0, 32'h5A000200});
    word(hdr(0, 2));
    word(hdr(0, 1));

    // unroutable id: two payload words skipped
    word(hdr(2, 7)); word(hdr(1, 0)); word(36'h5);
    idle(1, '0, '0);

    // six words into a four-deep queue without pops
    word(hdr(6, 0));
    for (int i = 1; i <= 6; i++) word(36'(i));
    word(hdr(1, 3)); word(36'hABC);
    idle(2, '0, '0);
    idle(1, '0, 4'b0001);
    idle(5, 4'b1001, '0);

    // fill app 2, then push and pop together while full, then reset mid-packet
    word(hdr(8, 2));
    for (int i = 1; i <= 4; i++) word(36'(16 + i));
    cyc(1'b1, 36'h25, 4'b0100, '0);
    word(36'h26);
    do_reset();
    word(hdr(2, 2)); word(36'h31); word(36'h32);
    idle(3, 4'b0100, '0);

    // random mix of headers, payload, gaps, pops, clears and occasional resets
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4) w = {4'($urandom), 8'hA5, 16'($urandom_range(0, 6)), 8'($urandom_range(0, 5))};
      else w = {4'($urandom), 32'($urandom)};
      v = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 399) == 0) do_reset();
      cyc(v, w, 4'($urandom) & 4'($urandom),
          ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
